// File: rtl/mdu_pkg.sv
// mdu_pkg: MD operation and FSM state encodings shared with the decoder and hazard unit
package mdu_pkg;
   typedef enum logic [3:0] {
      NONE  = 4'd0,
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MTHI  = 4'd5,
      MTLO  = 4'd6,
      MFHI  = 4'd7,
      MFLO  = 4'd8
   } md_op_t;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam int CNT_W = 4;
   function automatic logic is_arith(input md_op_t op);
      return op inside {MULT, MULTU, DIV, DIVU};
   endfunction
   function automatic logic is_div(input md_op_t op);
      return op inside {DIV, DIVU};
   endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage pipeline <-> multiply/divide controller signal bundle
interface mdu_ctrl_if;
   import mdu_pkg::*;
   logic        Req;
   md_op_t      MDOpE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic        MDUseD;
   logic        Start;
   logic        Busy;
   logic        StallMD;
   logic [31:0] HLE;
   logic [31:0] HI;
   logic [31:0] LO;
   modport master (output Req, MDOpE, RD1E, RD2E, MDUseD,
                   input  Start, Busy, StallMD, HLE, HI, LO);
   modport slave  (input  Req, MDOpE, RD1E, RD2E, MDUseD,
                   output Start, Busy, StallMD, HLE, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit mult/div result {HI,LO} plus divide-by-zero flag
module mdu_arith import mdu_pkg::*; (
   input  md_op_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] res,
   output logic        div_zero
);
   logic [31:0]        d;
   logic [63:0]        sp;
   logic [63:0]        up;
   logic signed [31:0] sq;
   logic signed [31:0] sr;
   assign div_zero = is_div(op) && (b == 32'd0);
   // a zero divisor is replaced so the dividers never produce X; the result is discarded anyway
   assign d  = div_zero ? 32'd1 : b;
   assign sp = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign up = {32'd0, a} * {32'd0, b};
   assign sq = $signed(a) / $signed(d);
   assign sr = $signed(a) % $signed(d);
   assign res = op == MULT  ? sp :
                op == MULTU ? up :
                op == DIV   ? {sr, sq} :
                op == DIVU  ? {a % d, a / d} : 64'd0;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO and the MD stall request
module mdu_ctrl import mdu_pkg::*; #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic       clk,
   input logic       reset,
   mdu_ctrl_if.slave bus
);
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi_tmp;
   logic [31:0]      lo_tmp;
   logic             pend;
   logic [63:0]      res;
   logic             div_zero;
   logic             idle_ok;

   mdu_arith u_arith (.op(bus.MDOpE), .a(bus.RD1E), .b(bus.RD2E), .res(res), .div_zero(div_zero));

   assign idle_ok     = (state == IDLE) && !bus.Req;
   assign bus.Start   = is_arith(bus.MDOpE) && idle_ok;
   assign bus.Busy    = state == BUSY;
   assign bus.StallMD = bus.MDUseD & (bus.Start | bus.Busy);
   assign bus.HLE     = bus.MDOpE == MFHI ? bus.HI : bus.MDOpE == MFLO ? bus.LO : 32'd0;

   // next state: start leaves IDLE, the last busy cycle returns to it
   always_comb
      state_n = bus.Start ? BUSY : (state == BUSY && cnt == '0) ? IDLE : state;

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_n;

   // latch result on start, count down while busy, commit at the end; mthi/mtlo only when idle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt    <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         pend   <= 1'b0;
         bus.HI <= '0;
         bus.LO <= '0;
      end else if (bus.Start) begin
         cnt    <= is_div(bus.MDOpE) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
         hi_tmp <= res[63:32];
         lo_tmp <= res[31:0];
         pend   <= !div_zero;
      end else if (bus.Busy) begin
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (cnt == '0 && pend) begin
            bus.HI <= hi_tmp;
            bus.LO <= lo_tmp;
         end
      end else if (idle_ok && bus.MDOpE == MTHI) begin
         bus.HI <= bus.RD1E;
      end else if (idle_ok && bus.MDOpE == MTLO) begin
         bus.LO <= bus.RD1E;
      end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vector bench for the multiply/divide controller
module tb_mdu_ctrl;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mdu_ctrl_if bus();

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      int          n;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] hi0;
      logic [31:0] lo0;
      int k;
      hi0 = bus.HI;
      lo0 = bus.LO;
      k = 0;
      bus.MDOpE = op;
      bus.RD1E = a;
      bus.RD2E = b;
      bus.Req = 1'b0;
      bus.MDUseD = 1'b1;
      #1;
      chk({name, ".start"}, bus.Start, 1);
      chk({name, ".stall0"}, bus.StallMD, 1);
      tick();
      bus.MDOpE = NONE;
      bus.RD1E = $urandom;
      bus.RD2E = $urandom;
      #1;
      while (bus.Busy && k < 20) begin
         chk({name, ".stall"}, bus.StallMD, 1);
         chk({name, ".hold_hi"}, bus.HI, hi0);
         chk({name, ".hold_lo"}, bus.LO, lo0);
         k++;
         tick();
      end
      chk({name, ".busy_cycles"}, k, n);
      chk({name, ".hi"}, bus.HI, hi);
      chk({name, ".lo"}, bus.LO, lo);
   endtask

   initial begin
      vecs[0] = '{MULT,  32'hFFFFFFFD, 32'd7,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
      vecs[3] = '{DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14};
      vecs[4] = '{DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[5] = '{DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
      vecs[6] = '{DIVU,  32'hFFFFFFFF, 32'h10,       10, 32'hF,        32'h0FFFFFFF};
      bus.Req = 1'b0;
      bus.MDOpE = NONE;
      bus.RD1E = '0;
      bus.RD2E = '0;
      bus.MDUseD = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("rst.busy", bus.Busy, 0);
      chk("rst.stall", bus.StallMD, 0);
      chk("rst.hi", bus.HI, 0);
      chk("rst.lo", bus.LO, 0);
      bus.MDOpE = MFHI;
      #1;
      chk("rst.hle", bus.HLE, 0);
      tick();

      for (int i = 0; i < 7; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].hi, vecs[i].lo);

      bus.MDOpE = MTLO;
      bus.RD1E = 32'h1234;
      tick();
      bus.MDOpE = MFLO;
      #1;
      chk("mtlo.hle", bus.HLE, 32'h1234);
      bus.MDOpE = MTHI;
      bus.RD1E = 32'hABCD;
      tick();
      bus.MDOpE = MFHI;
      #1;
      chk("mthi.hle", bus.HLE, 32'hABCD);
      bus.MDOpE = NONE;
      #1;
      chk("none.hle", bus.HLE, 0);

      bus.MDOpE = MTHI;
      bus.RD1E = 32'hDEAD;
      bus.Req = 1'b1;
      tick();
      bus.Req = 1'b0;
      bus.MDOpE = MFHI;
      #1;
      chk("mthi_req.hle", bus.HLE, 32'hABCD);

      bus.MDOpE = MULT;
      bus.RD1E = 32'd5;
      bus.RD2E = 32'd5;
      bus.Req = 1'b1;
      #1;
      chk("mult_req.start", bus.Start, 0);
      chk("mult_req.stall", bus.StallMD, 0);
      tick();
      bus.Req = 1'b0;
      bus.MDOpE = NONE;
      #1;
      chk("mult_req.busy", bus.Busy, 0);
      chk("mult_req.hi", bus.HI, 32'hABCD);
      chk("mult_req.lo", bus.LO, 32'h1234);

      bus.MDOpE = MULT;
      bus.RD1E = 32'd6;
      bus.RD2E = 32'd7;
      tick();
      bus.Req = 1'b1;
      bus.MDOpE = MTLO;
      bus.RD1E = 32'h77;
      bus.MDUseD = 1'b0;
      #1;
      chk("busy_req.nostall", bus.StallMD, 0);
      bus.MDUseD = 1'b1;
      repeat (5) tick();
      bus.Req = 1'b0;
      bus.MDOpE = NONE;
      #1;
      chk("busy_req.busy", bus.Busy, 0);
      chk("busy_req.hi", bus.HI, 0);
      chk("busy_req.lo", bus.LO, 32'd42);

      bus.MDOpE = MULT;
      bus.RD1E = 32'd2;
      bus.RD2E = 32'd3;
      tick();
      bus.RD1E = 32'd9;
      bus.RD2E = 32'd9;
      #1;
      chk("hazard.start", bus.Start, 0);
      tick();
      bus.MDOpE = MTHI;
      bus.RD1E = 32'h99;
      repeat (4) tick();
      bus.MDOpE = NONE;
      #1;
      chk("hazard.busy", bus.Busy, 0);
      chk("hazard.hi", bus.HI, 0);
      chk("hazard.lo", bus.LO, 32'd6);

      bus.MDOpE = MTHI;
      bus.RD1E = 32'h55;
      tick();
      bus.MDOpE = MTLO;
      tick();
      run_op("div0", DIV, 32'd9, 32'd0, 10, 32'h55, 32'h55);

      bus.MDOpE = DIVU;
      bus.RD1E = 32'd100;
      bus.RD2E = 32'd7;
      tick();
      bus.MDOpE = NONE;
      repeat (3) tick();
      chk("rst_mid.busy_before", bus.Busy, 1);
      reset = 1'b0;
      #1;
      chk("rst_mid.busy", bus.Busy, 0);
      chk("rst_mid.stall", bus.StallMD, 0);
      chk("rst_mid.hi", bus.HI, 0);
      chk("rst_mid.lo", bus.LO, 0);
      tick();
      reset = 1'b1;
      repeat (10) tick();
      chk("rst_mid.busy_after", bus.Busy, 0);
      chk("rst_mid.hi_after", bus.HI, 0);
      chk("rst_mid.lo_after", bus.LO, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
